vhm_event_reporter: RTL
=======================

# vhm_event_reporter

Parametrised event capture and serial reporting block for the virtual heart model harness. It monitors NUM_CH level inputs (node activations plus atrial/ventricular pace), detects rising edges, and timestamps them against a tick-driven counter. All edges seen in one cycle are bundled into a single record and queued in a FIFO. Records drain as framed 8N1 UART bytes, generalising the fixed two-channel header/counter transmitter to arbitrary channel count, timestamp width and buffering depth.

## Interface
- NUM_CH, 9, number of event channels (1..32); channel i reported as mask bit i
- TS_WIDTH, 32, timestamp width in bits; multiple of 8, 8..32
- FIFO_DEPTH, 16, record FIFO depth; power of two, ≥2
- CLKS_PER_BIT, 434, clk cycles per UART bit; ≥2
- MB, derived = ceil(NUM_CH/8), mask bytes per frame; TB, derived = TS_WIDTH/8
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset: synchronous, active-low
- tick  in  1  one-cycle strobe advancing the timestamp; already synchronous to clk
- ev_i  in  NUM_CH  event levels, synchronous to clk
- mask  in  NUM_CH  per-channel enable; 1 = report
- en  in  1  global capture enable
- clr_ovf  in  1  one-cycle strobe clearing overflow
- txd  out  1  UART serial output, idle high
- busy  out  1  high while a frame is on the wire or the FIFO is non-empty
- frame_done  out  1  one-cycle pulse after the last stop bit of each frame
- overflow  out  1  sticky: a record was dropped
- drop_cnt  out  8  saturating count of dropped records

## Operation
- Timestamp ts (TS_WIDTH): ts += 1 on each tick; wraps from all-ones to 0.
- Edge detect: ev_prev registers ev_i every cycle, including when en=0. edge = ev_i & ~ev_prev & mask, qualified by en.
- Record: if edge≠0, one record {edge, ts} is pushed in that cycle. ts is the value before any same-cycle tick increment. Simultaneous edges share one record.
- FIFO: push is accepted only if not full at the start of the cycle. A push while full drops the record, even with a same-cycle pop. A drop sets overflow and increments drop_cnt, which saturates at 255.
- clr_ovf clears overflow and drop_cnt. A drop in the same cycle wins: overflow=1, drop_cnt=1.
- Frame: sync byte 0xA5, then MB mask bytes, then TB timestamp bytes. Both fields are sent most-significant byte first; unused mask bits are 0. Bytes are back to back.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT cycles.
- TX FSM states:
  - IDLE: txd=1. Pops when the FIFO is non-empty and latches the record.
  - START
  - DATA: bit index 0..7.
  - STOP: advances the byte index. After the last byte it pulses frame_done and goes to IDLE; otherwise it goes to START with the next byte.
- No idle gap is inserted between consecutive frames beyond the IDLE cycle.

## Timing
- Reset values: txd=1, busy=0, frame_done=0, overflow=0, drop_cnt=0, ts=0, FIFO empty, FSM IDLE, ev_prev=all ones. Inputs already high at reset release therefore produce no event.
- Reset mid-frame aborts the frame: txd=1 on the cycle after rst_n is sampled low, and the queued records are lost.
- Edge at ev_i sampled at clk edge t: record written at edge t. IDLE pops at t+1. txd start bit is driven from t+2 when the FSM was idle.
- Frame length: (1+MB+TB)×10×CLKS_PER_BIT cycles.
- frame_done is high for exactly one cycle, coincident with the cycle after the final stop-bit period.
- busy goes high on the cycle after a push and low on the frame_done cycle when the FIFO is empty.

## Test plan
Test parameters: NUM_CH=9, TS_WIDTH=32, CLKS_PER_BIT=4, FIFO_DEPTH=4. Frame = 7 bytes = 280 cycles.
- Single event:
  - Stimulus: 5 ticks, then ev_i[0] rises, mask all ones, en=1.
  - Required: frame A5 00 01 00 00 00 05; start bit at push+2; one frame_done.
- Simultaneous edges with tick:
  - Stimulus: ev_i[2], ev_i[8] and tick in the same cycle with ts=7.
  - Required: one frame A5 01 04 00 00 00 07.
- Masking and enable:
  - Stimulus: mask[1]=0 with ev_i[1] rising; then en=0 with ev_i[3] rising, ev_i[3] low, en=1.
  - Required: no frames, txd constant 1, busy 0.
- Overflow:
  - Stimulus: 7 records spaced 2 cycles apart.
  - Required: first 5 transmitted (1 popped plus 4 queued); overflow=1; drop_cnt=2.
  - Stimulus: clr_ovf.
  - Required: both cleared.
- Reset mid-frame and wrap:
  - Stimulus: rst_n low during DATA of byte 3.
  - Required: txd=1 next cycle, busy=0, no frame_done.
  - Stimulus: preload ts=FFFFFFFF via ticks and an edge on the same cycle as a tick.
  - Required: frame shows FF FF FF FF; the next record shows 00 00 00 00.

Source files
------------

// File: rtl/vhm_event_reporter.sv
// -----------------------------------------------------------------------------
// vhm_event_reporter
//
// Captures rising edges on NUM_CH event channels of the virtual heart model,
// stamps them with a tick-driven timestamp, queues one record per cycle with
// edges, and serialises each record as a framed 8N1 UART message:
//   0xA5, MB mask bytes (MSB first), TB timestamp bytes (MSB first).
//
// Parameters
//   NUM_CH        number of event channels (1..32)
//   TS_WIDTH      timestamp width, multiple of 8 (8..32)
//   FIFO_DEPTH    record FIFO depth, power of two, >= 2
//   CLKS_PER_BIT  clk cycles per UART bit, >= 2
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   tick        one-cycle strobe advancing the timestamp
//   ev_i        event levels
//   mask        per-channel report enable (1 = report)
//   en          global capture enable
//   clr_ovf     one-cycle strobe clearing overflow and drop_cnt
//   txd         UART serial output, idle high
//   busy        frame on the wire or records queued
//   frame_done  one-cycle pulse in the cycle after the last stop bit
//   overflow    sticky flag: a record was dropped
//   drop_cnt    saturating count of dropped records
// -----------------------------------------------------------------------------
module vhm_event_reporter #(
    parameter int NUM_CH       = 9,
    parameter int TS_WIDTH     = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [NUM_CH-1:0] ev_i,
    input  logic [NUM_CH-1:0] mask,
    input  logic              en,
    input  logic              clr_ovf,
    output logic              txd,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int MB = (NUM_CH + 7) / 8;
    localparam int TB = TS_WIDTH / 8;
    localparam int NB = 1 + MB + TB;          // bytes per frame
    localparam int FW = NB * 8;               // frame width in bits
    localparam int RW = NUM_CH + TS_WIDTH;    // record width
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NB);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [NUM_CH-1:0]   ev_prev_q, ev_prev_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [RW-1:0]       mem_q [FIFO_DEPTH];

    state_t              state_q, state_d;
    logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BW-1:0]       byte_idx_q, byte_idx_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                txd_q, txd_d;
    logic                fin_q, fin_d;
    logic                frame_done_q, frame_done_d;

    // ---------------------------------------------------------------------
    // Capture and FIFO control
    // ---------------------------------------------------------------------
    logic [NUM_CH-1:0] ev_rise;
    logic              push, push_ok, drop, pop;
    logic              empty, full;
    logic [RW-1:0]     rd_rec;
    logic [MB*8-1:0]   mask_pad;
    logic [FW-1:0]     frame_load;
    logic [7:0]        cur_byte;
    logic              bit_end;

    assign ev_rise = ev_i & ~ev_prev_q & mask & {NUM_CH{en}};
    assign push    = |ev_rise;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Fullness is judged on the registered pointers, so a same-cycle pop
    // never makes room for a push.
    assign push_ok = push & ~full;
    assign drop    = push & full;
    assign pop     = (state_q == S_IDLE) && !empty;

    assign rd_rec  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mask_pad               = '0;
        mask_pad[NUM_CH-1:0]   = rd_rec[RW-1 -: NUM_CH];
    end

    assign frame_load = {SYNC_BYTE, mask_pad, rd_rec[TS_WIDTH-1:0]};

    always_comb begin
        ts_d       = tick ? ts_q + TS_WIDTH'(1) : ts_q;
        ev_prev_d  = ev_i;
        wr_ptr_d   = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        // A drop in the same cycle as clr_ovf wins and restarts the count at 1.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Record storage; not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {ev_rise, ts_q};
        end
    end

    // ---------------------------------------------------------------------
    // UART transmitter FSM
    // ---------------------------------------------------------------------
    // The frame is held in a shift register; the byte on the wire is always
    // the top byte, and the register shifts left by a byte after each stop bit.
    assign cur_byte = frame_q[FW-1 -: 8];
    assign bit_end  = (clk_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        txd_d      = 1'b1;
        fin_d      = 1'b0;

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    frame_d    = frame_load;
                    clk_cnt_d  = '0;
                    byte_idx_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                txd_d = cur_byte[bit_idx_q];
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (byte_idx_q == BYTE_LAST) begin
                        fin_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                        frame_d    = frame_q << 8;
                        state_d    = S_START;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // txd is registered from the current state, so the wire lags the FSM
        // by one cycle. fin_q marks the last stop-bit cycle on the wire and
        // frame_done follows one cycle later, after that bit has completed.
        frame_done_d = fin_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q         <= '0;
            ev_prev_q    <= '1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= 8'd0;
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            byte_idx_q   <= '0;
            frame_q      <= '0;
            txd_q        <= 1'b1;
            fin_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ts_q         <= ts_d;
            ev_prev_q    <= ev_prev_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            frame_q      <= frame_d;
            txd_q        <= txd_d;
            fin_q        <= fin_d;
            frame_done_q <= frame_done_d;
        end
    end

    // fin_q keeps busy high through the final stop-bit cycle on the wire.
    assign busy       = (state_q != S_IDLE) || !empty || fin_q;
    assign txd        = txd_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
